// File: rtl/cnt_drv.sv
// cnt_drv: command-side driver for the up/down counter.
// Accepts a target count over a valid/ready handshake. It then drives act and
// up_dwn_n for exactly |target - shadow| cycles, waits one settle cycle, and
// pulses done. A counter overflow locks the driver into a sticky error state.
// Optional macro CNT_DRV_CHECK_EN adds a count-vs-shadow consistency check in
// IDLE and DONE. A mismatch enters the error state in the same way as ovflw.
module cnt_drv #(
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tgt_valid,
  output logic                     tgt_ready,
  input  logic [COUNTER_WIDTH-1:0] tgt,
  output logic                     act,
  output logic                     up_dwn_n,
  input  logic [COUNTER_WIDTH-1:0] count,
  input  logic                     ovflw,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_SETTLE, S_DONE, S_ERR
  } state_t;

  state_t                   state, state_nxt;
  logic [COUNTER_WIDTH-1:0] shadow, shadow_nxt;
  logic [COUNTER_WIDTH-1:0] remaining, rem_nxt;
  logic                     dir_nxt;
  logic                     xfer, tgt_ge, fault;
  logic [COUNTER_WIDTH-1:0] diff;
  logic                     ready_nxt, act_nxt, busy_nxt, done_nxt, err_nxt;

  assign xfer   = tgt_valid & tgt_ready;
  assign tgt_ge = (tgt >= shadow);
  // Unsigned distance. There is no wrap, because a move never crosses the range ends.
  assign diff   = tgt_ge ? (tgt - shadow) : (shadow - tgt);

`ifdef CNT_DRV_CHECK_EN
  logic chk_skip;
  logic chk_fault;

  // The counter is known to be zero in the first cycle after reset, so that cycle is not checked.
  always_ff @(posedge clk) begin
    if (rst) chk_skip <= 1'b1;
    else     chk_skip <= 1'b0;
  end

  assign chk_fault = (((state == S_IDLE) && !chk_skip) || (state == S_DONE)) &&
                     (count != shadow);
  assign fault     = ovflw | chk_fault;
`else
  logic unused_count;
  assign unused_count = ^count;
  assign fault        = ovflw;
`endif

  // State register. Outputs are registered from the decoded next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shadow    <= '0;
      remaining <= '0;
      up_dwn_n  <= 1'b1;
      tgt_ready <= 1'b1;
      act       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      remaining <= rem_nxt;
      up_dwn_n  <= dir_nxt;
      tgt_ready <= ready_nxt;
      act       <= act_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state logic. A fault overrides every other transition.
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    rem_nxt    = remaining;
    dir_nxt    = up_dwn_n;
    case (state)
      S_IDLE: begin
        if (xfer) begin
          shadow_nxt = tgt;
          dir_nxt    = tgt_ge;
          rem_nxt    = diff;
          state_nxt  = (diff == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        rem_nxt = remaining - 1'b1;
        if (remaining <= 1) state_nxt = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_ERR;
    endcase
    if (fault) state_nxt = S_ERR;
  end

  // Output decode of the next state. The result is registered above.
  always_comb begin
    ready_nxt = 1'b0;
    act_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state_nxt)
      S_IDLE:   ready_nxt = 1'b1;
      S_RUN:    begin act_nxt = 1'b1; busy_nxt = 1'b1; end
      S_SETTLE: busy_nxt = 1'b1;
      S_DONE:   begin done_nxt = 1'b1; busy_nxt = 1'b1; end
      default:  err_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cnt_drv.sv
// Directed bench for cnt_drv. A behavioural up/down counter with one-cycle lag
// drives count and ovflw back into the DUT. Force controls let the bench inject
// an overflow or a wrong count value.
module tb_cnt_drv;

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [3:0] tgt;
  logic       act;
  logic       up_dwn_n;
  logic [3:0] count;
  logic       ovflw;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] model_cnt;
  logic       model_ovf;
  logic       force_ovf;
  logic       force_cnt;
  logic [3:0] force_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cnt_drv #(.COUNTER_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt       (tgt),
    .act       (act),
    .up_dwn_n  (up_dwn_n),
    .count     (count),
    .ovflw     (ovflw),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign count = force_cnt ? force_val : model_cnt;
  assign ovflw = model_ovf | force_ovf;

  // Counter model: it resets with ~rst, moves one step per act cycle, and latches overflow at the range ends.
  always @(posedge clk) begin
    if (rst) begin
      model_cnt <= 4'd0;
      model_ovf <= 1'b0;
    end else if (act) begin
      if (up_dwn_n) begin
        if (model_cnt == 4'hF) model_ovf <= 1'b1;
        else                   model_cnt <= model_cnt + 4'd1;
      end else begin
        if (model_cnt == 4'h0) model_ovf <= 1'b1;
        else                   model_cnt <= model_cnt - 4'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, tgt_ready, 1);
    chk({tag, "_act"},   act,       0);
    chk({tag, "_updn"},  up_dwn_n,  1);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_done"},  done,      0);
    chk({tag, "_err"},   err,       0);
  endtask

  // Transfer t in cycle 0, then check every cycle up to the point where tgt_ready returns.
  task automatic move(input logic [3:0] t, input int d, input logic dir);
    int done_c;
    done_c = (d == 0) ? 1 : d + 2;
    @(negedge clk);
    chk($sformatf("pre_ready_t%0d", t), tgt_ready, 1);
    tgt_valid = 1'b1;
    tgt       = t;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    tgt       = ~t;
    for (int k = 1; k <= done_c + 1; k++) begin
      @(negedge clk);
      chk($sformatf("act_t%0d_c%0d", t, k),   act,       (k <= d));
      if (k <= d) chk($sformatf("updn_t%0d_c%0d", t, k), up_dwn_n, dir);
      chk($sformatf("done_t%0d_c%0d", t, k),  done,      (k == done_c));
      chk($sformatf("ready_t%0d_c%0d", t, k), tgt_ready, (k == done_c + 1));
      chk($sformatf("busy_t%0d_c%0d", t, k),  busy,      (k <= done_c));
      if (k == done_c) chk($sformatf("count_t%0d", t), count, t);
    end
    chk($sformatf("ovflw_t%0d", t), ovflw, 0);
    chk($sformatf("err_t%0d", t),   err,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt       = 4'd0;
    force_ovf = 1'b0;
    force_cnt = 1'b0;
    force_val = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;

    // Basic moves: up by 5, down by 3, and a zero-length move.
    move(4'd5, 5, 1'b1);
    move(4'd2, 3, 1'b0);
    move(4'd2, 0, 1'b0);

    // Full-range sweep: 0 -> 15 -> 0.
    move(4'd0, 2, 1'b0);
    move(4'd15, 15, 1'b1);
    move(4'd0, 15, 1'b0);

    // Inject an overflow in the middle of a 10-cycle move.
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt       = 4'd10;
    @(posedge clk);
    #1 tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_act_c3", act, 1);
    force_ovf = 1'b1;
    @(negedge clk);
    force_ovf = 1'b0;
    chk("ovf_act",   act,       0);
    chk("ovf_err",   err,       1);
    chk("ovf_ready", tgt_ready, 0);
    chk("ovf_busy",  busy,      0);
    chk("ovf_done",  done,      0);
    tgt_valid = 1'b1;
    tgt       = 4'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("err_hold_err_%0d", k),  err,  1);
      chk($sformatf("err_hold_act_%0d", k),  act,  0);
      chk($sformatf("err_hold_done_%0d", k), done, 0);
      chk($sformatf("err_hold_rdy_%0d", k),  tgt_ready, 0);
    end
    tgt_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("ovf_rst");
    rst = 1'b0;

    // Reset during cycle 3 of a 10-cycle move.
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt       = 4'd10;
    @(posedge clk);
    #1 tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_act_c3", act, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid_nodone_%0d", k), done, 0);
    end
    move(4'd4, 4, 1'b1);

    // Force a wrong count value while the driver is in IDLE (shadow=4).
    force_cnt = 1'b1;
    force_val = 4'd7;
    @(negedge clk);
`ifdef CNT_DRV_CHECK_EN
    chk("chk_err",   err,       1);
    chk("chk_ready", tgt_ready, 0);
`else
    chk("chk_err",   err,       0);
    chk("chk_ready", tgt_ready, 1);
`endif
    force_cnt = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("end_rst");
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_drv.md
Name: cnt_drv

Overview:
- Command-side driver for the up/down counter state machine (act / up_dwn_n / count / ovflw interface).
- Accepts a target count over a valid/ready handshake. Drives act and up_dwn_n for exactly the cycles needed to move the counter to that target, then pulses done.
- Watches ovflw and locks into a sticky error state if the counter ever overflows.
- Sits between the control/test logic and the counter. The top level ties the counter's rst_n to ~rst so both blocks reset together.

Parameters:
- COUNTER_WIDTH, 4, width of target, shadow count and counter count.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- tgt_valid  input  1  target request valid
- tgt_ready  output  1  driver can accept a target
- tgt  input  COUNTER_WIDTH  requested counter value
- act  output  1  to counter: count enable
- up_dwn_n  output  1  to counter: 1 = up, 0 = down
- count  input  COUNTER_WIDTH  counter value from the counter
- ovflw  input  1  counter overflow flag (sticky in the counter)
- busy  output  1  a move is in progress
- done  output  1  one-cycle pulse when the move is complete
- err  output  1  sticky error

Behaviour:
Interface:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: tgt_ready=1, act=0, up_dwn_n=1, busy=0, done=0, err=0, shadow=0, remaining=0, state=IDLE.

Handshake:
- Transfer occurs at a rising edge with tgt_valid & tgt_ready.
- tgt_ready=1 only in IDLE. tgt is ignored when no transfer occurs.

Arithmetic:
- On transfer: dir = (tgt >= shadow); remaining = |tgt - shadow|, computed unsigned at COUNTER_WIDTH bits, with no wrap. Shadow <= tgt.
- The driver never requests a move across the range ends.

States:
- IDLE: tgt_ready=1. On transfer:
  - remaining==0 -> DONE.
  - otherwise -> RUN with act=1, up_dwn_n=dir.
- RUN: act=1 held for exactly D = remaining cycles; remaining decrements each cycle. On the last act cycle, act is cleared at the next edge -> SETTLE. up_dwn_n is constant throughout the move.
- SETTLE: act=0 for one cycle, covering the counter's one-cycle update lag -> DONE.
- DONE: done=1 for one cycle -> IDLE. done and tgt_ready are not high in the same cycle.

Timing, for a transfer in cycle 0:
- act is high in cycles 1..D.
- SETTLE is cycle D+1.
- done is in cycle D+2, and count==tgt in that cycle.
- tgt_ready returns in cycle D+3.
- For D=0: done in cycle 1, act never asserted.
- busy=1 in RUN, SETTLE and DONE.

Overflow:
- ovflw sampled high in any state -> ERR on the next edge.
- ERR: act=0, err=1, tgt_ready=0, busy=0. No done pulse, including if this aborts a move. ERR exits only on rst.

Reset mid-move:
- rst wins over every other event.
- act drops to 0 at the reset edge. No done pulse; the state returns to the reset values.

Simultaneous events:
- ovflw and the final act cycle together -> ERR.
- tgt_valid while busy is ignored (tgt_ready=0).

Optional Feature:
CNT_DRV_CHECK_EN
- Defined: in every IDLE cycle (except the cycle directly after reset) and in the DONE cycle, compare count against shadow. A mismatch enters ERR exactly like ovflw.
- Not defined: count is unused (left unconnected internally) and err is raised only by ovflw.

Test Plan:
- Reset, then tgt=5 -> act high cycles 1..5 with up_dwn_n=1; done in cycle 7; count=5.
- From 5, tgt=2 -> act high 3 cycles with up_dwn_n=0; done in cycle 5; count=2; ovflw stays 0.
- tgt equal to current value (2) -> no act; done in cycle 1; tgt_ready back in cycle 2.
- From 0, tgt=15 (act 15 cycles), then tgt=0 (act 15 cycles, up_dwn_n=0) -> count 15 then 0; ovflw never asserted; err=0.
- Force ovflw=1 mid-move -> next cycle act=0, err=1, tgt_ready=0, no done; new tgt_valid ignored until rst; after rst all outputs at reset values.
- rst asserted in cycle 3 of a 10-cycle move -> act=0 at that edge, no done; next tgt=4 from 0 completes normally. With CNT_DRV_CHECK_EN, forcing count=7 while shadow=4 in IDLE -> err=1 next cycle.
